d_flip_flop: RTL and testbench

Registered D-input capture block. It samples `d_i` on every rising clock edge and provides:
- the one-cycle registered value;
- a configurable-depth delayed copy;
- per-bit rising and falling edge pulses;
- a saturating count of output changes.

It is the basic state-holding primitive for control paths that need a clean registered copy of a level, plus edge information, in a single synchronous-reset clock domain.

---
 rtl/d_flip_flop.sv | 72 +++++++
 tb/tb_d_flip_flop.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - registered capture with delay line, edge pulses and change counter
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous active-high clear of all state
//   d_i       : data input, sampled every rising edge
//   q_o       : d_i registered once
//   qn_o      : bitwise inverse of q_o
//   q_dly_o   : d_i delayed by DEPTH register stages
//   rise_o    : per-bit 0->1 pulse of q_o, one cycle wide
//   fall_o    : per-bit 1->0 pulse of q_o, one cycle wide
//   chg_cnt_o : saturating count of cycles in which q_o changed
module d_flip_flop #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o,
    output logic [WIDTH-1:0] q_dly_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [CNT_W-1:0] chg_cnt_o
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_prev_r;
    logic [WIDTH-1:0] dly_r [DEPTH];
    logic [CNT_W-1:0] cnt_r;

    logic changed;
    logic cnt_full;

    // The counter looks at the registered pair, so an increment shows up
    // one cycle after the q_o change that caused it.
    assign changed  = (q_r != q_prev_r);
    assign cnt_full = &cnt_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Clearing q_prev_r together with q_r keeps a reset-forced
            // 1->0 on q_o from producing a fall pulse.
            q_r      <= '0;
            q_prev_r <= '0;
            cnt_r    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dly_r[k] <= '0;
            end
        end else begin
            q_r      <= d_i;
            q_prev_r <= q_r;
            dly_r[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                dly_r[k] <= dly_r[k-1];
            end
            if (changed && !cnt_full) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign q_o       = q_r;
    assign qn_o      = ~q_r;
    assign q_dly_o   = dly_r[DEPTH-1];
    assign rise_o    = q_r & ~q_prev_r;
    assign fall_o    = ~q_r & q_prev_r;
    assign chg_cnt_o = cnt_r;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - self-checking bench for d_flip_flop
module tb_d_flip_flop;

    logic       clk;
    logic       reset;
    logic [3:0] d;

    logic [3:0] q, qn, qdly, rise, fall;
    logic [7:0] cnt;

    logic       s_q, s_qn, s_dly, s_rise, s_fall;
    logic [1:0] s_cnt;

    int n_vec;
    int n_err;

    // Reference model: history of sampled inputs, newest first; a reset
    // edge wipes the whole history. Counts follow the "q changed during
    // the previous cycle" rule, saturating at the counter maximum.
    logic [3:0] hist [0:2];
    int         m_cnt;
    int         ms_cnt;

    d_flip_flop #(.WIDTH(4), .DEPTH(3), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_i       (d),
        .q_o       (q),
        .qn_o      (qn),
        .q_dly_o   (qdly),
        .rise_o    (rise),
        .fall_o    (fall),
        .chg_cnt_o (cnt)
    );

    d_flip_flop #(.WIDTH(1), .DEPTH(1), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .d_i       (d[0]),
        .q_o       (s_q),
        .qn_o      (s_qn),
        .q_dly_o   (s_dly),
        .rise_o    (s_rise),
        .fall_o    (s_fall),
        .chg_cnt_o (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, advance the model, then settle
    // on the falling edge where outputs are sampled.
    task automatic step(input logic r, input logic [3:0] dv);
        reset = r;
        d     = dv;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) hist[i] = 4'h0;
            m_cnt  = 0;
            ms_cnt = 0;
        end else begin
            if (hist[0] != hist[1] && m_cnt < 255) m_cnt++;
            if (hist[0][0] != hist[1][0] && ms_cnt < 3) ms_cnt++;
            for (int i = 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = dv;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 4'h0);
        step(1'b0, 4'h0);
        n_vec++; if (q !== 4'h0) begin n_err++; $display("FAIL reset_q: got %h want 0", q); end
        n_vec++; if (qn !== 4'hF) begin n_err++; $display("FAIL reset_qn: got %h want f", qn); end
        n_vec++; if (qdly !== 4'h0) begin n_err++; $display("FAIL reset_qdly: got %h want 0", qdly); end
        n_vec++; if ((rise | fall) !== 4'h0) begin n_err++; $display("FAIL reset_edges: got rise %h fall %h want 0", rise, fall); end
        n_vec++; if (cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        n_vec++; if ({s_q, s_qn, s_dly, s_cnt} !== 5'b01000) begin n_err++; $display("FAIL reset_sat: got q%b qn%b dly%b cnt%0d", s_q, s_qn, s_dly, s_cnt); end
    endtask

    task automatic test_rise_hold();
        step(1'b0, 4'hF);
        n_vec++; if (q !== 4'hF || rise !== 4'hF || fall !== 4'h0) begin n_err++; $display("FAIL rise_e1: got q %h rise %h fall %h want f f 0", q, rise, fall); end
        n_vec++; if (s_dly !== 1'b1) begin n_err++; $display("FAIL depth1_dly: got %b want 1", s_dly); end
        step(1'b0, 4'hF);
        n_vec++; if (rise !== 4'h0 || cnt !== 8'd1) begin n_err++; $display("FAIL rise_e2: got rise %h cnt %0d want 0 1", rise, cnt); end
        n_vec++; if (qdly !== 4'h0) begin n_err++; $display("FAIL dly_early: got %h want 0", qdly); end
        step(1'b0, 4'hF);
        n_vec++; if (qdly !== 4'hF || cnt !== 8'd1) begin n_err++; $display("FAIL dly_e3: got qdly %h cnt %0d want f 1", qdly, cnt); end
    endtask

    task automatic test_fall();
        step(1'b0, 4'h0);
        n_vec++; if (q !== 4'h0 || fall !== 4'hF || rise !== 4'h0 || cnt !== 8'd1) begin n_err++; $display("FAIL fall_e1: got q %h fall %h rise %h cnt %0d want 0 f 0 1", q, fall, rise, cnt); end
        step(1'b0, 4'h0);
        n_vec++; if (fall !== 4'h0 || cnt !== 8'd2) begin n_err++; $display("FAIL fall_e2: got fall %h cnt %0d want 0 2", fall, cnt); end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
        reset = 1'b1;
        #2;
        n_vec++; if (q !== 4'hF) begin n_err++; $display("FAIL async_rst: got q %h want f", q); end
        step(1'b1, 4'hF);
        n_vec++; if (q !== 4'h0 || fall !== 4'h0 || cnt !== 8'd0 || qdly !== 4'h0) begin n_err++; $display("FAIL mid_rst1: got q %h fall %h cnt %0d qdly %h want 0 0 0 0", q, fall, cnt, qdly); end
        step(1'b1, 4'hF);
        n_vec++; if (q !== 4'h0 || fall !== 4'h0 || cnt !== 8'd0 || qdly !== 4'h0) begin n_err++; $display("FAIL mid_rst2: got q %h fall %h cnt %0d qdly %h want 0 0 0 0", q, fall, cnt, qdly); end
    endtask

    task automatic test_release();
        step(1'b0, 4'hF);
        n_vec++; if (q !== 4'hF || rise !== 4'hF) begin n_err++; $display("FAIL release: got q %h rise %h want f f", q, rise); end
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
        n_vec++; if (qdly !== 4'hF) begin n_err++; $display("FAIL release_dly: got %h want f", qdly); end
    endtask

    task automatic test_saturation();
        int prev;
        step(1'b1, 4'h0);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, (i % 2 == 0) ? 4'h1 : 4'h0);
            n_vec++;
            if (s_cnt !== ms_cnt[1:0] || int'(s_cnt) < prev) begin
                n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, s_cnt, ms_cnt);
            end
            prev = int'(s_cnt);
        end
        n_vec++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL sat_final: got %0d want 3", s_cnt); end
    endtask

    task automatic test_random();
        logic       r;
        logic [3:0] dv;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            dv = 4'($urandom);
            step(r, dv);
            n_vec++;
            if (q !== hist[0] || qn !== ~hist[0] || qdly !== hist[2]) begin
                n_err++; $display("FAIL rnd_data[%0d]: got q %h qn %h qdly %h want %h %h %h", i, q, qn, qdly, hist[0], ~hist[0], hist[2]);
            end
            n_vec++;
            if (rise !== (hist[0] & ~hist[1]) || fall !== (~hist[0] & hist[1])) begin
                n_err++; $display("FAIL rnd_edges[%0d]: got rise %h fall %h want %h %h", i, rise, fall, hist[0] & ~hist[1], ~hist[0] & hist[1]);
            end
            n_vec++;
            if (cnt !== m_cnt[7:0] || s_cnt !== ms_cnt[1:0]) begin
                n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt, s_cnt, m_cnt, ms_cnt);
            end
            n_vec++;
            if (s_q !== hist[0][0] || s_dly !== hist[0][0] || s_rise !== (hist[0][0] & ~hist[1][0]) || s_fall !== (~hist[0][0] & hist[1][0])) begin
                n_err++; $display("FAIL rnd_sat[%0d]: got q %b dly %b rise %b fall %b", i, s_q, s_dly, s_rise, s_fall);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        m_cnt  = 0;
        ms_cnt = 0;
        for (int i = 0; i < 3; i++) hist[i] = 4'h0;
        reset = 1'b1;
        d     = 4'h0;

        test_reset();
        test_rise_hold();
        test_fall();
        test_mid_reset();
        test_release();
        test_saturation();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
